// File: rtl/segment_scan_decoder_pkg.sv
// Shared types and the active-low 7-segment decode table for the display scan monitor.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TRACK0   = 2'd1,
        TRACK1   = 2'd2,
        CONFLICT = 2'd3
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Index is the hex value; bit6=a ... bit0=g, a lit segment reads 0.
    localparam logic [6:0] SEG_TABLE [0:15] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Returns {legal, value}; value is 0 when the pattern is not in the table.
    function automatic logic [4:0] seg_decode(input logic [6:0] pattern);
        logic [4:0] res;
        res = 5'b0_0000;
        for (int i = 0; i < 16; i++) begin
            if (pattern == SEG_TABLE[i]) begin
                res = {1'b1, 4'(i)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/segment_scan_decoder_if.sv
// Display pins observed by the scan decoder and the recovered digit/status results.
interface segment_scan_decoder_if;
    logic       a0;
    logic       a1;
    logic [6:0] cathode;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic       blank0;
    logic       blank1;
    logic       valid0;
    logic       valid1;
    logic       update;
    logic       pattern_err;
    logic       ghost_err;

    modport master (
        output a0, a1, cathode,
        input  digit0, digit1, blank0, blank1, valid0, valid1,
        input  update, pattern_err, ghost_err
    );

    modport slave (
        input  a0, a1, cathode,
        output digit0, digit1, blank0, blank1, valid0, valid1,
        output update, pattern_err, ghost_err
    );
endinterface

// File: rtl/segment_scan_decoder_pin_sync.sv
// Two-flop synchronizer; resets to all ones so that idle active-low pins read inactive.
module pin_sync #(
    parameter int W = 1
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta_r;
    logic [W-1:0] sync_r;

    // Metastability chain
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta_r <= {W{1'b1}};
            sync_r <= {W{1'b1}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;
endmodule

// File: rtl/segment_scan_decoder.sv
// Watches a 2-digit multiplexed 7-segment bus, recovers each shown digit and flags
// illegal patterns, anode overlap and refresh stalls.
module segment_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TO_W           = 20
) (
    input  logic                 clock,
    input  logic                 reset_n,
    segment_scan_decoder_if.slave bus
);
    localparam logic [7:0]      STABLE_MAX = 8'(STABLE_CYCLES);
    localparam logic [TO_W-1:0] TO_MAX     = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_ONE     = TO_W'(1);
    localparam logic [TO_W-1:0] TO_ZERO    = TO_W'(0);

    logic [8:0]      tuple_s;
    logic [8:0]      prev_r;
    logic [7:0]      cnt_r;
    logic            done_r;
    scan_state_t     state_r;
    scan_state_t     state_nxt_s;
    logic [4:0]      dec_s;
    logic            legal_s;
    logic            blank_s;
    logic            stable_s;
    logic            changed_s;
    logic            commit0_s;
    logic            commit1_s;
    logic            ghost_s;
    logic [TO_W-1:0] to0_r;
    logic [TO_W-1:0] to1_r;
    logic [TO_W-1:0] to0_nxt_s;
    logic [TO_W-1:0] to1_nxt_s;
    logic [3:0]      digit0_r;
    logic [3:0]      digit1_r;
    logic            blank0_r;
    logic            blank1_r;
    logic            valid0_r;
    logic            valid1_r;
    logic            update_r;
    logic            pattern_err_r;
    logic            ghost_err_r;

    pin_sync #(.W(9)) u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       ({bus.a1, bus.a0, bus.cathode}),
        .q       (tuple_s)
    );

    // Scan state follows the synchronized anode pair
    always_comb begin
        state_nxt_s = IDLE;
        case (tuple_s[8:7])
            2'b11:   state_nxt_s = IDLE;
            2'b10:   state_nxt_s = TRACK0;
            2'b01:   state_nxt_s = TRACK1;
            2'b00:   state_nxt_s = CONFLICT;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Commit/ghost decisions; prev_r holds the tuple the stable count refers to
    always_comb begin
        commit0_s = 1'b0;
        commit1_s = 1'b0;
        ghost_s   = 1'b0;
        dec_s     = seg_decode(prev_r[6:0]);
        legal_s   = dec_s[4];
        blank_s   = (prev_r[6:0] == SEG_BLANK);
        stable_s  = (cnt_r == STABLE_MAX) && !done_r;
        changed_s = (tuple_s != prev_r) || (state_nxt_s != state_r);
        case (state_r)
            TRACK0:   commit0_s = stable_s;
            TRACK1:   commit1_s = stable_s;
            CONFLICT: ghost_s   = stable_s;
            IDLE:     ghost_s   = 1'b0;
            default:  ghost_s   = 1'b0;
        endcase
    end

    // Per-position stall counters, cleared by any commit to that position
    always_comb begin
        to0_nxt_s = to0_r;
        to1_nxt_s = to1_r;
        if (commit0_s) begin
            to0_nxt_s = TO_ZERO;
        end else if (to0_r != TO_MAX) begin
            to0_nxt_s = to0_r + TO_ONE;
        end else begin
            to0_nxt_s = to0_r;
        end
        if (commit1_s) begin
            to1_nxt_s = TO_ZERO;
        end else if (to1_r != TO_MAX) begin
            to1_nxt_s = to1_r + TO_ONE;
        end else begin
            to1_nxt_s = to1_r;
        end
    end

    // Stability tracking and one-commit-per-window flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_r <= 9'h1FF;
            cnt_r  <= 8'd0;
            done_r <= 1'b0;
            to0_r  <= TO_ZERO;
            to1_r  <= TO_ZERO;
        end else begin
            prev_r <= tuple_s;
            to0_r  <= to0_nxt_s;
            to1_r  <= to1_nxt_s;
            if (tuple_s != prev_r) begin
                cnt_r <= 8'd1;
            end else if (cnt_r < STABLE_MAX) begin
                cnt_r <= cnt_r + 8'd1;
            end else begin
                cnt_r <= cnt_r;
            end
            if (changed_s) begin
                done_r <= 1'b0;
            end else if (commit0_s || commit1_s || ghost_s) begin
                done_r <= 1'b1;
            end else begin
                done_r <= done_r;
            end
        end
    end

    // Registered results; a commit takes priority over a same-cycle timeout
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            digit0_r      <= 4'd0;
            digit1_r      <= 4'd0;
            blank0_r      <= 1'b0;
            blank1_r      <= 1'b0;
            valid0_r      <= 1'b0;
            valid1_r      <= 1'b0;
            update_r      <= 1'b0;
            pattern_err_r <= 1'b0;
            ghost_err_r   <= 1'b0;
        end else begin
            update_r      <= (commit0_s || commit1_s) && (legal_s || blank_s);
            pattern_err_r <= (commit0_s || commit1_s) && !(legal_s || blank_s);
            ghost_err_r   <= ghost_s;
            if (commit0_s) begin
                valid0_r <= legal_s || blank_s;
                if (legal_s) begin
                    digit0_r <= dec_s[3:0];
                    blank0_r <= 1'b0;
                end else if (blank_s) begin
                    blank0_r <= 1'b1;
                end else begin
                    blank0_r <= blank0_r;
                end
            end else if (to0_nxt_s == TO_MAX) begin
                valid0_r <= 1'b0;
            end else begin
                valid0_r <= valid0_r;
            end
            if (commit1_s) begin
                valid1_r <= legal_s || blank_s;
                if (legal_s) begin
                    digit1_r <= dec_s[3:0];
                    blank1_r <= 1'b0;
                end else if (blank_s) begin
                    blank1_r <= 1'b1;
                end else begin
                    blank1_r <= blank1_r;
                end
            end else if (to1_nxt_s == TO_MAX) begin
                valid1_r <= 1'b0;
            end else begin
                valid1_r <= valid1_r;
            end
        end
    end

    assign bus.digit0      = digit0_r;
    assign bus.digit1      = digit1_r;
    assign bus.blank0      = blank0_r;
    assign bus.blank1      = blank1_r;
    assign bus.valid0      = valid0_r;
    assign bus.valid1      = valid1_r;
    assign bus.update      = update_r;
    assign bus.pattern_err = pattern_err_r;
    assign bus.ghost_err   = ghost_err_r;
endmodule

// File: tb/tb_segment_scan_decoder.sv
// Directed bench for segment_scan_decoder: vector table plus latency, timeout and reset sequences.
module tb_segment_scan_decoder;

    typedef struct {
        logic       a0;
        logic       a1;
        logic [6:0] cath;
        int         cycles;
        logic [3:0] d0;
        logic [3:0] d1;
        logic       b0;
        logic       b1;
        logic       v0;
        logic       v1;
        int         n_upd;
        int         n_pat;
        int         n_gho;
    } vec_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    int   n_upd   = 0;
    int   n_pat   = 0;
    int   n_gho   = 0;
    vec_t vecs [9];

    always #5 clock = ~clock;

    segment_scan_decoder_if bus ();

    segment_scan_decoder #(
        .STABLE_CYCLES  (4),
        .TIMEOUT_CYCLES (50),
        .TO_W           (20)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        n_upd += int'(bus.update);
        n_pat += int'(bus.pattern_err);
        n_gho += int'(bus.ghost_err);
    endtask

    task automatic drive(input logic a0, input logic a1, input logic [6:0] cath);
        bus.a0      = a0;
        bus.a1      = a1;
        bus.cathode = cath;
        n_upd = 0;
        n_pat = 0;
        n_gho = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " digit0"}, int'(bus.digit0), 0);
        chk({tag, " digit1"}, int'(bus.digit1), 0);
        chk({tag, " blank0"}, int'(bus.blank0), 0);
        chk({tag, " blank1"}, int'(bus.blank1), 0);
        chk({tag, " valid0"}, int'(bus.valid0), 0);
        chk({tag, " valid1"}, int'(bus.valid1), 0);
        chk({tag, " update"}, int'(bus.update), 0);
        chk({tag, " pattern_err"}, int'(bus.pattern_err), 0);
        chk({tag, " ghost_err"}, int'(bus.ghost_err), 0);
    endtask

    initial begin
        // Commit lands 7 ticks into each window, so stall counters never reach 50 here.
        vecs[0] = '{1'b0, 1'b1, 7'b1001111, 20, 4'h1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 0};
        vecs[1] = '{1'b1, 1'b0, 7'b0001000, 20, 4'h1, 4'hA, 1'b0, 1'b0, 1'b1, 1'b1, 1, 0, 0};
        vecs[2] = '{1'b0, 1'b1, 7'b1001111, 20, 4'h1, 4'hA, 1'b0, 1'b0, 1'b1, 1'b1, 1, 0, 0};
        vecs[3] = '{1'b1, 1'b0, 7'b0001000, 20, 4'h1, 4'hA, 1'b0, 1'b0, 1'b1, 1'b1, 1, 0, 0};
        vecs[4] = '{1'b0, 1'b1, 7'b1111110, 10, 4'h1, 4'hA, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1, 0};
        vecs[5] = '{1'b0, 1'b0, 7'b0000110, 10, 4'h1, 4'hA, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1};
        vecs[6] = '{1'b0, 1'b1, 7'b1111111, 10, 4'h1, 4'hA, 1'b1, 1'b0, 1'b1, 1'b1, 1, 0, 0};
        vecs[7] = '{1'b1, 1'b0, 7'b0000000, 10, 4'h1, 4'h8, 1'b1, 1'b0, 1'b1, 1'b1, 1, 0, 0};
        vecs[8] = '{1'b0, 1'b1, 7'b0000000, 10, 4'h8, 4'h8, 1'b0, 1'b0, 1'b1, 1'b1, 1, 0, 0};

        drive(1'b1, 1'b1, 7'h7F);
        repeat (3) tick();
        chk_all_zero("reset");
        reset_n = 1'b1;
        repeat (3) tick();

        // First commit: pins change before edge 0, result appears at edge 6
        drive(1'b0, 1'b1, 7'b0000110);
        repeat (6) tick();
        chk("lat early update", int'(bus.update), 0);
        chk("lat early valid0", int'(bus.valid0), 0);
        tick();
        chk("lat update", int'(bus.update), 1);
        chk("lat digit0", int'(bus.digit0), 3);
        chk("lat valid0", int'(bus.valid0), 1);
        chk("lat blank0", int'(bus.blank0), 0);
        n_upd = 0;
        repeat (10) tick();
        chk("hold no repeat update", n_upd, 0);

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].a0, vecs[i].a1, vecs[i].cath);
            repeat (vecs[i].cycles) tick();
            chk($sformatf("v%0d digit0", i), int'(bus.digit0), int'(vecs[i].d0));
            chk($sformatf("v%0d digit1", i), int'(bus.digit1), int'(vecs[i].d1));
            chk($sformatf("v%0d blank0", i), int'(bus.blank0), int'(vecs[i].b0));
            chk($sformatf("v%0d blank1", i), int'(bus.blank1), int'(vecs[i].b1));
            chk($sformatf("v%0d valid0", i), int'(bus.valid0), int'(vecs[i].v0));
            chk($sformatf("v%0d valid1", i), int'(bus.valid1), int'(vecs[i].v1));
            chk($sformatf("v%0d update pulses", i), n_upd, vecs[i].n_upd);
            chk($sformatf("v%0d pattern_err pulses", i), n_pat, vecs[i].n_pat);
            chk($sformatf("v%0d ghost_err pulses", i), n_gho, vecs[i].n_gho);
        end

        // Stall: digit0=8 committed 3 edges before the end of vecs[8]
        drive(1'b1, 1'b1, 7'h7F);
        repeat (46) tick();
        chk("timeout valid0 before 50", int'(bus.valid0), 1);
        tick();
        chk("timeout valid0 at 50", int'(bus.valid0), 0);
        chk("timeout digit0 held", int'(bus.digit0), 8);
        chk("timeout valid1", int'(bus.valid1), 0);
        chk("timeout digit1 held", int'(bus.digit1), 8);
        chk("idle update pulses", n_upd, 0);

        // Reset in the middle of a stable window
        drive(1'b0, 1'b1, 7'b0100100);
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        repeat (3) tick();
        reset_n = 1'b1;
        n_upd = 0;
        repeat (6) tick();
        chk("post-reset early update", n_upd, 0);
        chk("post-reset early valid0", int'(bus.valid0), 0);
        tick();
        chk("post-reset update", int'(bus.update), 1);
        chk("post-reset digit0", int'(bus.digit0), 5);
        chk("post-reset valid0", int'(bus.valid0), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/segment_scan_decoder.md
Name: segment_scan_decoder

Overview:
- Receive-side counterpart to the 2-digit multiplexed 7-segment driver: watches the driver's anode (a0, a1) and cathode[6:0] lines and recovers the digit shown on each position.
- Used as an on-chip display monitor and self-check: it confirms that the record/play clip numbers driven to the display match the intended values.
- Flags illegal segment patterns, anode overlap (ghosting) and refresh stalls.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples required before a digit is committed; legal range 1..255.
- TIMEOUT_CYCLES, 1000000: cycles without a commit on a digit before that digit is declared stale; must be >= 2.
- TO_W, 20: timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- a0  in  1  anode digit 0, active-low
- a1  in  1  anode digit 1, active-low
- cathode  in  7  segments, active-low; bit6=a, bit5=b … bit0=g
- digit0  out  4  last committed hex value, position 0
- digit1  out  4  last committed hex value, position 1
- blank0  out  1  position 0 last committed as all-segments-off
- blank1  out  1  position 1 last committed as all-segments-off
- valid0  out  1  position 0 holds a fresh, legal value
- valid1  out  1  position 1 holds a fresh, legal value
- update  out  1  one-cycle pulse on any commit
- pattern_err  out  1  one-cycle pulse: stable pattern not in the decode table
- ghost_err  out  1  one-cycle pulse: both anodes active for STABLE_CYCLES samples

Behaviour:
- Reset values: all outputs 0. Internal state: FSM=IDLE, counters=0, sync flops=1 (inactive).
- Input sync: a0, a1 and cathode each pass through a 2-flop synchronizer. All logic uses the synchronized copies.
- Sample tuple: {a1, a0, cathode}. The stable counter increments while the tuple equals the previous cycle's tuple, saturating at STABLE_CYCLES. It reloads to 1 on any change.
- FSM states:
  - IDLE: both anodes high.
  - TRACK0: a0 low only.
  - TRACK1: a1 low only.
  - CONFLICT: both anodes low.
  - The state follows the synchronized anodes every cycle.
  - A commit-done flag clears on every state change or tuple change.
- Commit condition: in TRACK0/TRACK1, stable count reaches STABLE_CYCLES and commit-done is clear. On that edge:
  - If the pattern is in the table: digitN = decoded value, blankN = 0, validN = 1.
  - If the pattern is all-off (7'h7F): blankN = 1, validN = 1, digitN holds.
  - If the pattern is illegal: validN = 0, digitN/blankN hold, pattern_err pulses.
  - update pulses on a legal or blank commit only.
  - commit-done is set, so there is exactly one commit per stable window.
- Latency: for a pin change sampled at edge 0, outputs update at edge STABLE_CYCLES+2.
- Decode table (active-low, a..g):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- CONFLICT: no commit. ghost_err pulses once when the stable count reaches STABLE_CYCLES in this state.
- Timeout: each position has its own counter, cleared on a commit to that position (legal, blank or illegal) and incremented otherwise, saturating. When it reaches TIMEOUT_CYCLES, validN = 0. Digit and blank values hold.
- Simultaneous events:
  - A commit and a timeout on the same edge: the commit wins.
  - Only one position can commit per cycle.
- Reset mid-operation: all state clears immediately. The first commit after release needs a full STABLE_CYCLES+2 window.
- IDLE: no action other than timeout counting.

Decomposition:
- Package seg_scan_pkg:
  - scan_state_t enum (IDLE, TRACK0, TRACK1, CONFLICT)
  - SEG_BLANK = 7'h7F
  - 16-entry active-low pattern constant array
  - function seg_decode(cathode) returning {legal, value[3:0]}
- Sub-module: pin_sync, a parameterized-width 2-flop synchronizer, instantiated once for the 9 input bits.

Test Plan:
- Hold a0=0, a1=1, cathode=7'b0000110 (STABLE_CYCLES=4) -> at edge 6: digit0=3, valid0=1, blank0=0, update pulses exactly once; no further pulses while held.
- Alternate a0/a1 every 20 cycles with 7'b1001111 / 7'b0001000 -> digit0=1, digit1=A, both valid; one update per anode window.
- Apply a0=0 with cathode=7'b1111110 for 10 cycles -> pattern_err one pulse, valid0=0, digit0 unchanged.
- Apply a0=0 and a1=0 together for 10 cycles -> ghost_err one pulse, no update, digits unchanged.
- Use TIMEOUT_CYCLES=50, commit digit0=8, then hold a0=a1=1 for 60 cycles -> valid0 drops at cycle 50 after the commit, digit0 stays 8.
- Assert reset_n=0 mid-window, release after 3 cycles -> all outputs 0; the next commit appears a full 6 edges after stable input.
